// File: rtl/mix_columns_engine.sv
// Iterative GF(2^SYM_W) MixColumns engine, forward or inverse, one column per clock.
// Optional 16-bit completed-block counter port blk_cnt when MIXCOL_BLK_CNT_EN is defined.
//
// state | meaning
// IDLE  | ready for a new block
// BUSY  | mixing column col_idx of the work register
// DONE  | result held on out_data until out_ready
module mix_columns_engine #(
   parameter int                SYM_W    = 4,
   parameter logic [SYM_W-1:0]  POLY     = {{(SYM_W-2){1'b0}}, 2'b11},
   parameter int                NUM_COLS = 1,
   localparam int               DATA_W   = 4*SYM_W*NUM_COLS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_inv,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
`ifdef MIXCOL_BLK_CNT_EN
   output logic [15:0]       blk_cnt,
`endif
   output logic              busy
);

   localparam int COL_W = 4*SYM_W;
   localparam int CW    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_COLS-1);

   if (SYM_W < 4) begin : g_bad_sym_w
      $error("mix_columns_engine: SYM_W must be >= 4");
   end
   if (NUM_COLS < 1) begin : g_bad_num_cols
      $error("mix_columns_engine: NUM_COLS must be >= 1");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state, state_nx;
   logic [DATA_W-1:0]   work;
   logic                inv_q;
   logic [CW-1:0]       col_idx;
   logic [COL_W-1:0]    col_cur, col_new;

   function automatic logic [SYM_W-1:0] xtime(input logic [SYM_W-1:0] x);
      return {x[SYM_W-2:0], 1'b0} ^ (x[SYM_W-1] ? POLY : '0);
   endfunction

   function automatic logic [SYM_W-1:0] gf_mulk(input logic [SYM_W-1:0] x, input logic [3:0] k);
      logic [SYM_W-1:0] p, acc;
      p   = x;
      acc = '0;
      for (int i = 0; i < 4; i++) begin
         if (k[i]) acc ^= p;
         p = xtime(p);
      end
      return acc;
   endfunction

   // Both matrices are circulant: row r uses the base row rotated right by r.
   function automatic logic [COL_W-1:0] mix_col(input logic [COL_W-1:0] col, input logic inv);
      logic [SYM_W-1:0] s [4];
      logic [SYM_W-1:0] o;
      logic [3:0]       cf [4];
      logic [COL_W-1:0] res;
      if (inv) cf = '{4'hE, 4'hB, 4'hD, 4'h9};
      else     cf = '{4'h2, 4'h3, 4'h1, 4'h1};
      res = '0;
      for (int j = 0; j < 4; j++) s[j] = col[COL_W-1-j*SYM_W -: SYM_W];
      for (int r = 0; r < 4; r++) begin
         o = '0;
         for (int j = 0; j < 4; j++) o ^= gf_mulk(s[j], cf[2'(j-r)]);
         res[COL_W-1-r*SYM_W -: SYM_W] = o;
      end
      return res;
   endfunction

   always_comb begin
      col_cur = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
         if (col_idx == CW'(c)) col_cur = work[DATA_W-1-c*COL_W -: COL_W];
      end
      col_new = mix_col(col_cur, inv_q);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid) state_nx = BUSY;
         BUSY:    if (col_idx == LAST) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out_data  = work;

   always_ff @(posedge clk) begin
      if (rst) begin
         work    <= '0;
         inv_q   <= 1'b0;
         col_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work    <= in_data;
                  inv_q   <= in_inv;
                  col_idx <= '0;
               end
            end
            BUSY: begin
               for (int c = 0; c < NUM_COLS; c++) begin
                  if (col_idx == CW'(c)) work[DATA_W-1-c*COL_W -: COL_W] <= col_new;
               end
               col_idx <= (col_idx == LAST) ? '0 : col_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef MIXCOL_BLK_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)                          blk_cnt <= '0;
      else if (out_valid && out_ready)  blk_cnt <= blk_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_mix_columns_engine.sv
// Scoreboard bench for mix_columns_engine (NUM_COLS=3, SYM_W=4) with a GF reference model.
// Also covers blk_cnt when MIXCOL_BLK_CNT_EN is defined.
module tb_mix_columns_engine;

   localparam int SYM_W    = 4;
   localparam int NUM_COLS = 3;
   localparam int COL_W    = 4*SYM_W;
   localparam int DATA_W   = COL_W*NUM_COLS;
   localparam int POLY_I   = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              in_inv = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic              busy;
`ifdef MIXCOL_BLK_CNT_EN
   logic [15:0]       blk_cnt;
`endif

   int                checks = 0;
   int                failures = 0;
   int unsigned       cyc = 0;
   int                hs_cnt = 0;
   bit                bp_en = 1'b0;
   logic [DATA_W-1:0] exp_q [$];
   int unsigned       acc_q [$];

   mix_columns_engine #(.SYM_W(SYM_W), .POLY(4'h3), .NUM_COLS(NUM_COLS)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef MIXCOL_BLK_CNT_EN
      .blk_cnt(blk_cnt),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference: carry-less product reduced by the full field polynomial.
   function automatic int gmul(input int a, input int b);
      int p = 0;
      for (int i = 0; i < SYM_W; i++) if (((b >> i) & 1) != 0) p ^= (a << i);
      for (int i = 2*SYM_W-2; i >= SYM_W; i--)
         if (((p >> i) & 1) != 0) p ^= (((1 << SYM_W) | POLY_I) << (i - SYM_W));
      return p;
   endfunction

   function automatic logic [DATA_W-1:0] model(input logic [DATA_W-1:0] d, input logic inv);
      logic [DATA_W-1:0] r;
      int base [4];
      int s [4];
      int o;
      if (inv) base = '{14, 11, 13, 9};
      else     base = '{2, 3, 1, 1};
      r = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
         for (int j = 0; j < 4; j++) s[j] = int'(d[DATA_W-1-c*COL_W-j*SYM_W -: SYM_W]);
         for (int row = 0; row < 4; row++) begin
            o = 0;
            for (int j = 0; j < 4; j++) o ^= gmul(s[j], base[(j - row + 4) % 4]);
            r[DATA_W-1-c*COL_W-row*SYM_W -: SYM_W] = SYM_W'(o);
         end
      end
      return r;
   endfunction

   // Monitor: latency, hold-while-stalled and data checks.
   logic              prev_ov = 1'b0, prev_or = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;
   always @(negedge clk) begin
      if (rst) begin
         prev_ov = 1'b0;
      end else begin
         if (out_valid && !prev_ov) begin
            if (acc_q.size() == 0) check("spurious_valid", 1, 0);
            else check("latency", DATA_W'(cyc - acc_q.pop_front()), DATA_W'(NUM_COLS));
         end
         if (prev_ov && !prev_or) begin
            check("hold_valid", DATA_W'(out_valid), 1);
            check("hold_data", out_data, prev_data);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out", 1, 0);
            else check("out_data", out_data, exp_q.pop_front());
            hs_cnt++;
         end
         prev_ov   = out_valid;
         prev_or   = out_ready;
         prev_data = out_data;
      end
   end

   always @(posedge clk) begin
      #2;
      if (bp_en) out_ready = 1'($urandom_range(0, 1));
   end

   task automatic send(input logic [DATA_W-1:0] d, input logic inv, input logic [DATA_W-1:0] exp);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 0, 1);
         return;
      end
      in_valid = 1'b1;
      in_data  = d;
      in_inv   = inv;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      exp_q.push_back(exp);
      acc_q.push_back(cyc);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", DATA_W'(exp_q.size()), 0);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DATA_W-1:0] d;
      logic              m;
      logic [DATA_W-1:0] snap;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", DATA_W'(out_valid), 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", DATA_W'(in_ready), 1);
      check("rst_busy", DATA_W'(busy), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;

      send(48'h1000_FFFF_0000, 1'b0, 48'h2113_FFFF_0000);
      send(48'h2113_1000_FFFF, 1'b1, 48'h1000_E9DB_FFFF);
      send(48'hFFFF_0000_1000, 1'b1, 48'hFFFF_0000_E9DB);
      send(48'h0000_FFFF_2113, 1'b1, 48'h0000_FFFF_1000);
      send(48'h0000_FFFF_0000, 1'b0, 48'h0000_FFFF_0000);
      drain();

      // Inputs during BUSY/DONE must be ignored; result must hold under stall.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      d = {$urandom, $urandom};
      send(d, 1'b0, model(d, 1'b0));
      for (int i = 0; i < NUM_COLS + 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = {$urandom, $urandom};
         in_inv   = 1'b1;
         check("in_ready_busy", DATA_W'(in_ready), 0);
         check("busy_high", DATA_W'(busy), 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      snap = out_data;
      repeat (5) @(negedge clk);
      check("stall_data", out_data, snap);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();

      // Reset in the middle of a block, then reset together with in_valid.
      send(48'h1234_5678_9ABC, 1'b0, model(48'h1234_5678_9ABC, 1'b0));
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      exp_q.delete();
      acc_q.delete();
      hs_cnt = 0;
      check("midrst_out_valid", DATA_W'(out_valid), 0);
      check("midrst_out_data", out_data, 0);
      check("midrst_in_ready", DATA_W'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = 48'hDEAD_BEEF_0001;
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("rst_wins_busy", DATA_W'(busy), 0);
      check("rst_wins_data", out_data, 0);
      send(48'h1000_0000_0000, 1'b0, 48'h2113_0000_0000);
      drain();

      // Randomized blocks with random backpressure.
      bp_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         d = {$urandom, $urandom};
         m = 1'($urandom_range(0, 1));
         send(d, m, model(d, m));
      end
      drain();
      bp_en = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);

`ifdef MIXCOL_BLK_CNT_EN
      check("blk_cnt", DATA_W'(blk_cnt), DATA_W'(hs_cnt));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mix_columns_engine.md
Name: mix_columns_engine

Overview:
- Parametrised, multi-column GF(2^SYM_W) MixColumns unit for the cryptographic core.
- Performs forward or inverse mixing on a block of NUM_COLS four-symbol columns.
- Iterative datapath: one column per clock. Block-level valid/ready handshake on both sides.
- Replaces fixed single-column 16-bit mixing with a width-, column- and mode-generic engine.

Parameters:
- SYM_W, 4: symbol width in bits. Must be >= 4; elaboration error otherwise.
- POLY, 4'h3: low SYM_W bits of the field reduction polynomial (default x^4+x+1).
- NUM_COLS, 1: columns per block. Must be >= 1.
- DATA_W, 4*SYM_W*NUM_COLS: derived block width. Not overridable.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  engine can accept a block.
- in_inv  in  1  mode: 0 = forward, 1 = inverse; sampled at accept.
- in_data  in  DATA_W  input block.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_W  result block.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Layout: column 0 occupies the MSB-most 4*SYM_W bits. Within a column, symbol a is MSB-most, then b, c, d.
- xtime(x) = (x<<1) truncated to SYM_W bits, XOR POLY if x[SYM_W-1] = 1. Multiply by constant k = XOR of xtime^i(x) over the set bits i of k.
- Forward:
  - o0 = 2a^3b^c^d
  - o1 = a^2b^3c^d
  - o2 = a^b^2c^3d
  - o3 = 3a^b^c^2d
- Inverse:
  - o0 = Ea^Bb^Dc^9d
  - o1 = 9a^Eb^Bc^Dd
  - o2 = Da^9b^Ec^Bd
  - o3 = Ba^Db^9c^Ed
  - These matrices are exact inverses for any SYM_W >= 4 and any POLY.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid at a clock edge: latch in_data into the work register, latch in_inv, set col_idx = 0, go to BUSY.
- BUSY:
  - Each edge: replace column col_idx in the work register with its mixed value, then increment col_idx.
  - After column NUM_COLS-1: go to DONE.
  - Latency: out_valid rises exactly NUM_COLS edges after the accept edge.
- DONE:
  - out_valid = 1 and out_data = work register.
  - out_data and out_valid stay stable while out_ready = 0.
  - On out_ready at an edge: go to IDLE; out_valid drops on that edge.
- in_ready = 0 in BUSY and DONE. in_valid is ignored there; no data or mode is captured.
- out_valid, out_data and busy change only on clock edges (registered).
- Minimum block period: NUM_COLS+2 cycles with out_ready tied high.
- col_idx counter width: clog2(NUM_COLS), minimum 1. Resets to 0 on return to IDLE.
- Reset (any state, including mid-block):
  - Next edge: state = IDLE, out_valid = 0, out_data = 0, busy = 0, in_ready = 1, col_idx = 0.
  - Any pending block is discarded.
- Reset asserted together with in_valid: reset wins; no accept.

Optional Feature:
- Macro: MIXCOL_BLK_CNT_EN.
- Defined:
  - Adds output port blk_cnt (16 bits).
  - Increments on each output handshake (out_valid & out_ready).
  - Wraps 0xFFFF -> 0x0000. Reset value 0.
- Undefined: port and counter absent. All other behaviour identical.

Test Plan:
- NUM_COLS=1, forward, in_data=0x1000 -> out_data=0x2113, out_valid exactly 1 cycle after accept.
- NUM_COLS=1, inverse: in_data=0x1000 -> 0xE9DB; in_data=0x2113 -> 0x1000 (round trip).
- NUM_COLS=1, in_data=0xFFFF, both modes -> 0xFFFF. in_data=0x0000 -> 0x0000.
- NUM_COLS=2, forward, in_data=0x1000FFFF -> 0x2113FFFF with 2-cycle latency. During BUSY, toggle in_valid with new data and in_inv -> ignored, in_ready=0.
- Hold out_ready=0 for 5 cycles -> out_data stable. Assert rst in mid-BUSY -> next cycle out_valid=0, out_data=0, in_ready=1; next block processes correctly.
- MIXCOL_BLK_CNT_EN defined: 3 completed blocks -> blk_cnt=3. Force count 0xFFFF, one more block -> 0x0000.
